// File: rtl/txn_timer_pkg.sv
// Shared types and constants for the transaction budget timer bank.
package txn_timer_pkg;

    // Per-slot timer state
    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StRun     = 2'd1,
        StExpired = 2'd2
    } slot_state_e;

    // Width of the optional aggregate timeout counter
    localparam int unsigned TotalCntWidth = 16;

endpackage

// File: rtl/txn_timer_slot.sv
// One timeout slot: IDLE/RUN/EXPIRED FSM plus a down-counter clocked by the tick pulse.
// Requests arrive already decoded for this slot; each is judged against the registered state.
module txn_timer_slot
    import txn_timer_pkg::*;
#(
    parameter int unsigned CntWidth = 10
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                tick_i,
    input  logic                start_i,
    input  logic                stop_i,
    input  logic                clr_i,
    input  logic [CntWidth-1:0] budget_i,
    output slot_state_e         state_o,
    output logic                illegal_o,
    output logic                expire_o
);

    slot_state_e         state_q, state_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;

    // Next-state, counter update, request legality and expiry pulse
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        illegal_o = 1'b0;
        expire_o  = 1'b0;

        // A request that does not match the current state is flagged and otherwise ignored
        if (start_i && (state_q != StIdle)) begin
            illegal_o = 1'b1;
        end
        if (stop_i && (state_q != StRun)) begin
            illegal_o = 1'b1;
        end
        if (clr_i && (state_q != StExpired)) begin
            illegal_o = 1'b1;
        end

        case (state_q)
            StIdle: begin
                // Arming never decrements, even if a tick lands in the same cycle
                if (start_i) begin
                    cnt_d = budget_i;
                    if (budget_i == '0) begin
                        state_d  = StExpired;
                        expire_o = 1'b1;
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                // Completion wins over an expiring tick in the same cycle
                if (stop_i) begin
                    state_d = StIdle;
                end else if (tick_i) begin
                    if (cnt_q == CntWidth'(1)) begin
                        state_d  = StExpired;
                        cnt_d    = '0;
                        expire_o = 1'b1;
                    end else if (cnt_q != '0) begin
                        cnt_d = cnt_q - CntWidth'(1);
                    end
                end
            end
            StExpired: begin
                if (clr_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // State and counter registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/txn_budget_timer.sv
// Bank of NumSlots transaction timeout timers driven by the prescaler tick.
// Decodes slot indices, flags illegal requests on err_o and raises a registered irq_o.
// Optional feature: define TXN_TIMER_TOTAL_CNT_EN to add the saturating total_timeouts_o counter.
module txn_budget_timer
    import txn_timer_pkg::*;
#(
    parameter int unsigned  NumSlots = 4,
    parameter int unsigned  CntWidth = 10,
    localparam int unsigned SlotIdxW = (NumSlots > 1) ? $clog2(NumSlots) : 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     tick_i,
    input  logic                     start_i,
    input  logic [SlotIdxW-1:0]      start_slot_i,
    input  logic [CntWidth-1:0]      budget_i,
    input  logic                     stop_i,
    input  logic [SlotIdxW-1:0]      stop_slot_i,
    input  logic                     clr_i,
    input  logic [SlotIdxW-1:0]      clr_slot_i,
    output logic [NumSlots-1:0]      busy_o,
    output logic [NumSlots-1:0]      timeout_o,
    output logic                     irq_o,
    output logic                     err_o
`ifdef TXN_TIMER_TOTAL_CNT_EN
    ,
    output logic [TotalCntWidth-1:0] total_timeouts_o
`endif
);

    // One wider than the index so NumSlots itself is representable
    localparam logic [SlotIdxW:0] SlotLimit = (SlotIdxW + 1)'(NumSlots);

    logic [NumSlots-1:0] start_hit, stop_hit, clr_hit;
    logic [NumSlots-1:0] illegal, expire;
    slot_state_e         slot_state [NumSlots];
    logic                start_oor, stop_oor, clr_oor;
    logic                err_d, err_q;
    logic                irq_q;

    // Index values with no slot behind them are always illegal
    assign start_oor = start_i && ({1'b0, start_slot_i} >= SlotLimit);
    assign stop_oor  = stop_i && ({1'b0, stop_slot_i} >= SlotLimit);
    assign clr_oor   = clr_i && ({1'b0, clr_slot_i} >= SlotLimit);

    for (genvar g = 0; g < NumSlots; g++) begin : g_slot
        assign start_hit[g] = start_i && (start_slot_i == SlotIdxW'(g));
        assign stop_hit[g]  = stop_i && (stop_slot_i == SlotIdxW'(g));
        assign clr_hit[g]   = clr_i && (clr_slot_i == SlotIdxW'(g));

        txn_timer_slot #(
            .CntWidth (CntWidth)
        ) u_slot (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .tick_i    (tick_i),
            .start_i   (start_hit[g]),
            .stop_i    (stop_hit[g]),
            .clr_i     (clr_hit[g]),
            .budget_i  (budget_i),
            .state_o   (slot_state[g]),
            .illegal_o (illegal[g]),
            .expire_o  (expire[g])
        );

        // Status comes straight from registered slot state
        assign busy_o[g]    = (slot_state[g] == StRun);
        assign timeout_o[g] = (slot_state[g] == StExpired);
    end

    // Any illegal or out-of-range request this cycle becomes a one-cycle error pulse
    always_comb begin
        err_d = (|illegal) | start_oor | stop_oor | clr_oor;
    end

    // Error pulse and interrupt registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            err_q <= err_d;
            irq_q <= |timeout_o;
        end
    end

    assign err_o = err_q;
    assign irq_o = irq_q;

`ifdef TXN_TIMER_TOTAL_CNT_EN
    logic [TotalCntWidth:0]   total_sum;
    logic [TotalCntWidth-1:0] total_d, total_q;

    // Add this cycle's expiry popcount, saturating at all-ones
    always_comb begin
        total_sum = {1'b0, total_q};
        for (int unsigned i = 0; i < NumSlots; i++) begin
            total_sum = total_sum + (TotalCntWidth + 1)'(expire[i]);
        end
        total_d = total_sum[TotalCntWidth] ? '1 : total_sum[TotalCntWidth-1:0];
    end

    // Aggregate timeout counter register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            total_q <= '0;
        end else begin
            total_q <= total_d;
        end
    end

    assign total_timeouts_o = total_q;
`else
    // Expiry pulses only feed the optional counter
    logic unused_expire;
    assign unused_expire = ^expire;
`endif

endmodule

// File: tb/tb_txn_budget_timer.sv
// Scoreboard bench for txn_budget_timer: a cycle model predicts outputs, expectations are
// queued when stimulus is driven and compared after the clock edge.
module tb_txn_budget_timer;

    localparam int NumSlots = 4;
    localparam int CntWidth = 10;

    logic                clk_i = 1'b0;
    logic                rst_ni;
    logic                tick_i;
    logic                start_i;
    logic [1:0]          start_slot_i;
    logic [CntWidth-1:0] budget_i;
    logic                stop_i;
    logic [1:0]          stop_slot_i;
    logic                clr_i;
    logic [1:0]          clr_slot_i;
    logic [3:0]          busy_o;
    logic [3:0]          timeout_o;
    logic                irq_o;
    logic                err_o;
`ifdef TXN_TIMER_TOTAL_CNT_EN
    logic [15:0]         total_timeouts_o;
`endif

    always #5 clk_i = ~clk_i;

    txn_budget_timer #(
        .NumSlots (NumSlots),
        .CntWidth (CntWidth)
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .tick_i           (tick_i),
        .start_i          (start_i),
        .start_slot_i     (start_slot_i),
        .budget_i         (budget_i),
        .stop_i           (stop_i),
        .stop_slot_i      (stop_slot_i),
        .clr_i            (clr_i),
        .clr_slot_i       (clr_slot_i),
        .busy_o           (busy_o),
        .timeout_o        (timeout_o),
        .irq_o            (irq_o),
        .err_o            (err_o)
`ifdef TXN_TIMER_TOTAL_CNT_EN
        ,
        .total_timeouts_o (total_timeouts_o)
`endif
    );

    typedef struct {
        logic [3:0] busy;
        logic [3:0] tmo;
        logic       irq;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   m_st[4];   // 0 idle, 1 run, 2 expired
    int   m_cnt[4];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Tick every fourth cycle
    function automatic bit next_tick();
        return (cyc % 4) == 3;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_st[i]  = 0;
            m_cnt[i] = 0;
        end
    endtask

    // Drive one cycle of requests, predict the result, then compare after the edge
    task automatic step(input bit st, input int ss, input int bud,
                        input bit sp, input int ps, input bit cl, input int cs);
        exp_t e;
        int   n_st[4];
        int   n_cnt[4];
        bit   stopped[4];
        bit   tk;
        tk           = next_tick();
        tick_i       = tk;
        start_i      = st;
        start_slot_i = ss[1:0];
        budget_i     = bud[CntWidth-1:0];
        stop_i       = sp;
        stop_slot_i  = ps[1:0];
        clr_i        = cl;
        clr_slot_i   = cs[1:0];

        e.err = 1'b0;
        e.irq = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_st[i]    = m_st[i];
            n_cnt[i]   = m_cnt[i];
            stopped[i] = 1'b0;
            if (m_st[i] == 2) e.irq = 1'b1;
        end
        if (st) begin
            if (m_st[ss] != 0) e.err = 1'b1;
            else begin
                n_cnt[ss] = bud;
                n_st[ss]  = (bud == 0) ? 2 : 1;
            end
        end
        if (sp) begin
            if (m_st[ps] != 1) e.err = 1'b1;
            else begin
                n_st[ps]    = 0;
                stopped[ps] = 1'b1;
            end
        end
        if (cl) begin
            if (m_st[cs] != 2) e.err = 1'b1;
            else n_st[cs] = 0;
        end
        if (tk) begin
            for (int i = 0; i < 4; i++) begin
                if (m_st[i] == 1 && !stopped[i]) begin
                    if (m_cnt[i] == 1) begin
                        n_st[i]  = 2;
                        n_cnt[i] = 0;
                    end else if (m_cnt[i] != 0) begin
                        n_cnt[i] = m_cnt[i] - 1;
                    end
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            m_st[i]    = n_st[i];
            m_cnt[i]   = n_cnt[i];
            e.busy[i]  = (n_st[i] == 1);
            e.tmo[i]   = (n_st[i] == 2);
        end
        exp_q.push_back(e);

        @(posedge clk_i);
        #1;
        cyc++;
        tick_i  = 1'b0;
        start_i = 1'b0;
        stop_i  = 1'b0;
        clr_i   = 1'b0;

        e = exp_q.pop_front();
        check_eq($sformatf("busy@%0d", cyc), busy_o, e.busy);
        check_eq($sformatf("timeout@%0d", cyc), timeout_o, e.tmo);
        check_eq($sformatf("irq@%0d", cyc), irq_o, e.irq);
        check_eq($sformatf("err@%0d", cyc), err_o, e.err);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic idle_to_tick();
        for (int i = 0; i < 4; i++) begin
            if (next_tick()) break;
            idle();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ticks;
        int errs;
        rst_ni       = 1'b0;
        tick_i       = 1'b0;
        start_i      = 1'b0;
        start_slot_i = '0;
        budget_i     = '0;
        stop_i       = 1'b0;
        stop_slot_i  = '0;
        clr_i        = 1'b0;
        clr_slot_i   = '0;
        model_reset();
        @(posedge clk_i);
        #1;
        check_eq("rst_busy", busy_o, 0);
        check_eq("rst_timeout", timeout_o, 0);
        check_eq("rst_irq", irq_o, 0);
        check_eq("rst_err", err_o, 0);
        rst_ni = 1'b1;
        idle();

        // Slot 0, budget 3: expires on the 3rd tick, irq one cycle later
        step(1, 0, 3, 0, 0, 0, 0);
        ticks = 0;
        for (int i = 0; i < 40; i++) begin
            if (timeout_o[0]) break;
            if (next_tick()) ticks++;
            idle();
        end
        check_eq("s0_timeout", timeout_o[0], 1);
        check_eq("s0_ticks", ticks, 3);
        check_eq("s0_irq_lag", irq_o, 0);
        idle();
        check_eq("s0_irq", irq_o, 1);

        // Slot 1, budget 5, stopped after 2 ticks
        step(1, 1, 5, 0, 0, 0, 0);
        ticks = 0;
        for (int i = 0; i < 40; i++) begin
            if (ticks == 2) break;
            if (next_tick()) ticks++;
            idle();
        end
        step(0, 0, 0, 1, 1, 0, 0);
        check_eq("s1_busy", busy_o[1], 0);
        check_eq("s1_err", err_o, 0);
        for (int i = 0; i < 24; i++) idle();
        check_eq("s1_no_timeout", timeout_o[1], 0);

        // Slot 2, budget 1, stop coincides with its first tick
        step(1, 2, 1, 0, 0, 0, 0);
        idle_to_tick();
        step(0, 0, 0, 1, 2, 0, 0);
        check_eq("s2_busy", busy_o[2], 0);
        check_eq("s2_timeout", timeout_o[2], 0);
        check_eq("s2_err", err_o, 0);
        for (int i = 0; i < 8; i++) idle();
        check_eq("s2_no_timeout", timeout_o[2], 0);

        // Slot 3: double start, clr while RUN, stop while IDLE
        errs = 0;
        step(1, 3, 500, 0, 0, 0, 0);
        errs += int'(err_o);
        step(1, 3, 9, 0, 0, 0, 0);
        errs += int'(err_o);
        check_eq("s3_still_busy", busy_o[3], 1);
        step(0, 0, 0, 0, 0, 1, 3);
        errs += int'(err_o);
        check_eq("s3_clr_ignored", {timeout_o[3], busy_o[3]}, 2'b01);
        step(0, 0, 0, 1, 3, 0, 0);
        errs += int'(err_o);
        step(0, 0, 0, 1, 3, 0, 0);
        errs += int'(err_o);
        check_eq("s3_err_count", errs, 3);
        check_eq("s3_idle", {timeout_o[3], busy_o[3]}, 2'b00);

        // Slot 0: clear, zero budget, clear, re-arm
        step(0, 0, 0, 0, 0, 1, 0);
        check_eq("z_clr", timeout_o[0], 0);
        step(1, 0, 0, 0, 0, 0, 0);
        check_eq("z_timeout", timeout_o[0], 1);
        step(0, 0, 0, 0, 0, 1, 0);
        check_eq("z_clr2", timeout_o[0], 0);
        step(1, 0, 7, 0, 0, 0, 0);
        check_eq("z_rearm", busy_o[0], 1);
        check_eq("z_rearm_err", err_o, 0);

        // All slots busy, then asynchronous reset between edges
        step(1, 1, 100, 0, 0, 0, 0);
        step(1, 2, 100, 0, 0, 0, 0);
        step(1, 3, 100, 0, 0, 0, 0);
        check_eq("all_busy", busy_o, 4'hF);
        #2;
        rst_ni = 1'b0;
        #1;
        check_eq("arst_busy", busy_o, 0);
        check_eq("arst_timeout", timeout_o, 0);
        check_eq("arst_irq", irq_o, 0);
        check_eq("arst_err", err_o, 0);
`ifdef TXN_TIMER_TOTAL_CNT_EN
        check_eq("arst_total", total_timeouts_o, 0);
`endif
        model_reset();
        @(posedge clk_i);
        #1;
        cyc++;
        rst_ni = 1'b1;

        // Four slots armed inside one tick window expire together
        idle_to_tick();
        step(1, 0, 2, 0, 0, 0, 0);
        step(1, 1, 2, 0, 0, 0, 0);
        step(1, 2, 2, 0, 0, 0, 0);
        step(1, 3, 2, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            if (timeout_o != 4'h0) break;
            idle();
        end
        check_eq("sim_timeout", timeout_o, 4'hF);
`ifdef TXN_TIMER_TOTAL_CNT_EN
        check_eq("sim_total", total_timeouts_o, 4);
`endif
        idle();
        check_eq("sim_irq", irq_o, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1, i);
        idle();
        check_eq("end_irq", irq_o, 0);
        check_eq("end_queue", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
